// File: rtl/instr_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_pkg : shared widths, reset PC and NOP word for the fetch stage
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package instr_fetch_unit_pkg;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 16;
  localparam int RESET_PC_DEF = 0;
  localparam logic [15:0] NOP_WORD = 16'h0000;
endpackage

`default_nettype wire

// File: rtl/fetch_prefetch_buf.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_buf : one-word prefetch slot (slot B) with load/pop/flush
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_prefetch_buf
  import instr_fetch_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // A load in the same cycle as a pop replaces the popped word, so it wins.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= DATA_W'(NOP_WORD);
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit : handshaked instruction fetcher with PC, IR and prefetch
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic              PClock,
  input  logic              Resetn,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] IR,
  output logic              Run,
  input  logic              Done,
  input  logic              PCLoad,
  input  logic [ADDR_W-1:0] PCValue,
  output logic              Busy
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              run_q, run_d;
  logic              pending_q, pending_d;
  logic              discard_q, discard_d;

  logic [DATA_W-1:0] pf_data;
  logic              pf_valid;
  logic              pf_load, pf_pop, pf_flush;
  logic              pf_valid_next;

  logic fire, jump, consume, take_ret, a_free, issue;

  always_comb begin
    pc_d          = pc_q;
    ir_d          = ir_q;
    run_d         = run_q;
    pending_d     = 1'b0;
    discard_d     = 1'b0;
    pf_load       = 1'b0;
    pf_pop        = 1'b0;
    pf_flush      = 1'b0;
    pf_valid_next = pf_valid;
    issue         = 1'b0;

    fire     = Done & run_q;
    jump     = fire & PCLoad;
    consume  = fire & ~PCLoad;
    take_ret = pending_q & ~discard_q;
    a_free   = ~run_q | consume;

    if (jump) begin
      // A read in flight keeps the port busy one more cycle; its data is dropped.
      run_d     = 1'b0;
      pf_flush  = 1'b1;
      pc_d      = PCValue;
      pending_d = pending_q;
      discard_d = pending_q;
    end else begin
      if (consume && pf_valid) begin
        ir_d   = pf_data;
        pf_pop = 1'b1;
      end
      if (take_ret) begin
        if (a_free && !pf_valid) begin
          ir_d  = MemData;
          run_d = 1'b1;
        end else begin
          pf_load = 1'b1;
        end
      end else if (consume && !pf_valid) begin
        run_d = 1'b0;
      end

      pf_valid_next = pf_load | (pf_valid & ~pf_pop);
      issue         = (~pending_q | take_ret) & ~(run_d & pf_valid_next);
      if (issue) begin
        pending_d = 1'b1;
        pc_d      = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge PClock or negedge Resetn) begin
    if (!Resetn) begin
      pc_q      <= ADDR_W'(RESET_PC);
      ir_q      <= DATA_W'(NOP_WORD);
      run_q     <= 1'b0;
      pending_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      run_q     <= run_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
    end
  end

  fetch_prefetch_buf #(
    .DATA_W (DATA_W)
  ) u_pf_buf (
    .clk       (PClock),
    .rst_n     (Resetn),
    .load      (pf_load),
    .load_data (MemData),
    .pop       (pf_pop),
    .flush     (pf_flush),
    .data      (pf_data),
    .valid     (pf_valid)
  );

  assign MemAddr = pc_q;
  assign IR      = ir_q;
  assign Run     = run_q;
  assign Busy    = pending_q | pf_valid;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit : directed stimulus, queue-based fetch model, per-cycle compare
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        Resetn;
  logic [4:0]  MemAddr;
  logic [15:0] MemData;
  logic [15:0] IR;
  logic        Run;
  logic        Done;
  logic        PCLoad;
  logic [4:0]  PCValue;
  logic        Busy;

  logic [15:0] mem [32];
  logic [15:0] mem_q;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  instr_fetch_unit dut (
    .PClock  (clk),
    .Resetn  (Resetn),
    .MemAddr (MemAddr),
    .MemData (MemData),
    .IR      (IR),
    .Run     (Run),
    .Done    (Done),
    .PCLoad  (PCLoad),
    .PCValue (PCValue),
    .Busy    (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge clk) mem_q <= mem[MemAddr];
  assign MemData = mem_q;

  // Model: the occupied instruction slots form an ordered queue whose head is IR.
  logic [15:0] mq[$];
  logic [15:0] m_ir   = 16'h0;
  int          m_pc   = 0;
  bit          m_pend = 0;
  int          m_paddr = 0;
  bit          m_hold = 0;

  task automatic model_step();
    bit fire, can_issue;
    if (!Resetn) begin
      mq.delete();
      m_ir   = 16'h0;
      m_pc   = 0;
      m_pend = 0;
      m_hold = 0;
    end else begin
      fire = Done && (mq.size() != 0);
      if (fire && PCLoad) begin
        mq.delete();
        m_pc   = int'(PCValue);
        m_hold = m_pend;
      end else begin
        can_issue = !(m_pend && m_hold);
        if (fire) void'(mq.pop_front());
        if (m_pend && !m_hold) mq.push_back(mem[m_paddr]);
        m_pend = 0;
        m_hold = 0;
        if (can_issue && mq.size() < 2) begin
          m_pend  = 1;
          m_paddr = m_pc;
          m_pc    = (m_pc + 1) % 32;
        end
      end
      if (mq.size() != 0) m_ir = mq[0];
    end
  endtask

  always @(posedge clk or negedge Resetn) model_step();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_ir",   32'(IR),      32'(m_ir));
      chk("model_run",  32'(Run),     32'(mq.size() != 0));
      chk("model_addr", 32'(MemAddr), 32'(m_pc));
      chk("model_busy", 32'(Busy),    32'(m_pend || mq.size() == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 Resetn = 1'b0;
    @(posedge clk);
    #1 Resetn = 1'b1;
  endtask

  initial begin
    Resetn  = 1'b0;
    Done    = 1'b0;
    PCLoad  = 1'b0;
    PCValue = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 16'hE000 + 16'(i);
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;

    // Reset state
    tick();
    chk("rst_ir",   32'(IR),      32'h0);
    chk("rst_run",  32'(Run),     32'h0);
    chk("rst_addr", 32'(MemAddr), 32'h0);
    chk("rst_busy", 32'(Busy),    32'h0);
    cmp_en = 1;
    Resetn = 1'b1;

    // Idle fill: first word after two edges, prefetch then holds Mem[1]
    tick();
    chk("fill_e1_run",  32'(Run),     32'h0);
    chk("fill_e1_addr", 32'(MemAddr), 32'h1);
    tick();
    chk("fill_e2_ir",  32'(IR),  32'h1234);
    chk("fill_e2_run", 32'(Run), 32'h1);
    tick();
    chk("fill_e3_addr", 32'(MemAddr), 32'h2);
    chk("fill_e3_busy", 32'(Busy),    32'h1);
    chk("fill_e3_ir",   32'(IR),      32'h1234);

    // Done while Run=0 has no effect
    do_reset();
    Done = 1'b1;
    tick();
    chk("idle_done_run",  32'(Run),     32'h0);
    chk("idle_done_addr", 32'(MemAddr), 32'h1);
    Done = 1'b0;
    tick();
    chk("idle_done_ir",  32'(IR),  32'h1234);
    chk("idle_done_run2", 32'(Run), 32'h1);

    // Back-to-back consumption
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[20] = 16'hBEEF;
    do_reset();
    Done = 1'b1;
    tick();
    tick();
    chk("b2b_ir0", 32'(IR), 32'h1111);
    tick();
    chk("b2b_ir1", 32'(IR), 32'h2222);
    chk("b2b_run1", 32'(Run), 32'h1);
    tick();
    chk("b2b_ir2", 32'(IR), 32'h3333);
    tick();
    chk("b2b_ir3", 32'(IR), 32'h4444);
    chk("b2b_run3", 32'(Run), 32'h1);

    // Jump with a read in flight: target in IR three edges later
    PCLoad  = 1'b1;
    PCValue = 5'd20;
    tick();
    chk("jmp_run0",  32'(Run),     32'h0);
    chk("jmp_ir0",   32'(IR),      32'h4444);
    chk("jmp_addr0", 32'(MemAddr), 32'd20);
    Done   = 1'b0;
    PCLoad = 1'b0;
    tick();
    chk("jmp_run1",  32'(Run),     32'h0);
    chk("jmp_ir1",   32'(IR),      32'h4444);
    chk("jmp_addr1", 32'(MemAddr), 32'd20);
    tick();
    chk("jmp_run2",  32'(Run),     32'h0);
    chk("jmp_addr2", 32'(MemAddr), 32'd21);
    tick();
    chk("jmp_ir3",  32'(IR),  32'hBEEF);
    chk("jmp_run3", 32'(Run), 32'h1);

    // Wrap-around from pc=30 via a jump with nothing in flight (two-edge latency)
    mem[30] = 16'hAAAA; mem[31] = 16'hBBBB; mem[0] = 16'hCCCC;
    do_reset();
    tick();
    tick();
    chk("wrap_fill_ir", 32'(IR), 32'hCCCC);
    tick();
    Done    = 1'b1;
    PCLoad  = 1'b1;
    PCValue = 5'd30;
    tick();
    chk("wrap_jmp_run",  32'(Run),     32'h0);
    chk("wrap_jmp_addr", 32'(MemAddr), 32'd30);
    chk("wrap_jmp_busy", 32'(Busy),    32'h0);
    Done   = 1'b0;
    PCLoad = 1'b0;
    tick();
    chk("wrap_addr31", 32'(MemAddr), 32'd31);
    tick();
    chk("wrap_ir_a",  32'(IR),      32'hAAAA);
    chk("wrap_run_a", 32'(Run),     32'h1);
    chk("wrap_addr0", 32'(MemAddr), 32'd0);
    Done = 1'b1;
    tick();
    chk("wrap_ir_b",  32'(IR),      32'hBBBB);
    chk("wrap_addr1", 32'(MemAddr), 32'd1);
    tick();
    chk("wrap_ir_c",  32'(IR),  32'hCCCC);
    chk("wrap_run_c", 32'(Run), 32'h1);
    Done = 1'b0;

    // Asynchronous reset mid-stream with both slots full
    tick();
    tick();
    tick();
    chk("mid_run",  32'(Run),  32'h1);
    chk("mid_busy", 32'(Busy), 32'h1);
    #2 Resetn = 1'b0;
    #1;
    chk("mid_rst_ir",   32'(IR),      32'h0);
    chk("mid_rst_run",  32'(Run),     32'h0);
    chk("mid_rst_addr", 32'(MemAddr), 32'h0);
    chk("mid_rst_busy", 32'(Busy),    32'h0);
    @(posedge clk);
    #1 Resetn = 1'b1;
    tick();
    tick();
    chk("refetch_ir",  32'(IR),  32'hCCCC);
    chk("refetch_run", 32'(Run), 32'h1);

    tick();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
